fetch_stage: RTL
================

Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage RISC-V core.
- Holds PCF and computes the next PC from the EX-stage redirect (PCSrcE, targets).
- Drives the single-cycle instruction-memory handshake and delivers InstrD/PCD/PCPlus4D to decode.
- Consumes stallF, stallD and flushD from the hazard unit, and returns fetchWait so the hazard unit can count memory-wait bubbles.

Parameters:
XLEN, 32, datapath and PC width
RESET_PC, 32'h0000_0000, PCF value after reset
NOP_INSTR, 32'h0000_0013, instruction injected on flush or bubble (addi x0,x0,0)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
stallF  in  1  hold PCF
stallD  in  1  hold IF/ID register
flushD  in  1  clear IF/ID register to bubble
PCSrcE  in  2  00 PC+4, 01 PCTargetE (branch/jal), 10 ALUResultE (jalr), 11 reserved (treated as 00)
PCTargetE  in  XLEN  branch/jal target
ALUResultE  in  XLEN  jalr target
imemAddr  out  XLEN  equals PCF
imemReq  out  1  fetch request
imemRdata  in  32  instruction word, valid when imemReady=1
imemReady  in  1  instruction returned this cycle
InstrD  out  32  decode instruction
PCD  out  XLEN  PC of InstrD
PCPlus4D  out  XLEN  PCD+4
validD  out  1  InstrD is a real instruction
fetchWait  out  1  state==WAIT, to hazard unit
fetchCount  out  32  valid instructions loaded into D
bubbleCount  out  32  bubbles loaded into D because of memory wait

Behaviour:
- Reset (async, any cycle, including mid-wait):
  - PCF=RESET_PC, state=FETCH, imemReq=0 during reset.
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, validD=0.
  - Both counters =0.
- imemReq=1 whenever rst=0; imemAddr=PCF combinationally. The response is same-cycle when imemReady=1.
- Target alignment:
  - Bits [1:0] of both targets are forced to 0 when loaded into PCF.
  - PCF[1:0] is always 00.
- PCF update priority, per clock:
  1. PCSrcE==01 or 10: redirect to the selected target. Overrides stallF and memory wait.
  2. stallF: hold.
  3. imemReady=0: hold.
  4. Otherwise PCF+4, wrapping modulo 2^XLEN.
- FSM:
  - FETCH → WAIT when imemReady=0 and no redirect/stallF.
  - WAIT → FETCH on imemReady=1 or redirect.
  - Any state → FETCH on rst.
  - fetchWait=1 only in WAIT.
  - A redirect in WAIT abandons the outstanding word; the new address is presented next cycle.
- IF/ID register priority, per clock:
  1. flushD: bubble (InstrD=NOP_INSTR, validD=0, PCD=0, PCPlus4D=0). Wins over stallD.
  2. stallD: hold all D outputs and counters.
  3. imemReady=1 and no redirect: load InstrD=imemRdata, PCD=PCF, PCPlus4D=PCF+4, validD=1; fetchCount+1.
  4. imemReady=0 or redirect without flushD: load bubble; bubbleCount+1 only when imemReady=0.
- Counters wrap at 2^32; no saturation.
- Latency: instruction at PCF appears on InstrD one clock after the cycle imemReady=1. Taken redirect costs 2 bubbles (D flushed, E flushed by the hazard unit).
- Simultaneous events:
  - stallF+stallD with PCSrcE!=00 (load-use under a taken branch): PCF redirects; flushD from the hazard unit clears D.
  - stallF=1 with stallD=0 is not produced by the hazard unit; if it occurs, D loads per rules 3/4.
- PCSrcE=11: behaves as 00, no redirect.

Test Plan:
- Reset then free-run with imemReady=1, imemRdata=PC-tagged words → PCF 0,4,8,12; InstrD follows one cycle later; validD=1; fetchCount=3 after 4 clocks.
- stallF=stallD=1 for 2 cycles at PCF=8 → PCF held at 8, InstrD/PCD (PCD=4) held, counters unchanged; resumes at 12.
- PCSrcE=01, PCTargetE=0x103, flushD=1 at PCF=16 → next PCF=0x100; D bubble (NOP, validD=0); following cycle InstrD from 0x100; PCSrcE=10, ALUResultE=0x200 → PCF=0x200.
- imemReady=0 for 3 cycles at PCF=0x20 → fetchWait=1, PCF held, 3 bubbles, bubbleCount=3; then InstrD=word@0x20, validD=1.
- Redirect PCSrcE=01 to 0x40 during WAIT with stallF=1 → PCF=0x40, state FETCH, abandoned word never reaches D.
- Assert rst asynchronously mid-WAIT between clock edges → immediate PCF=RESET_PC, validD=0, counters 0, imemReq=0 until rst deasserts.

Source files
------------

// File: rtl/fetch_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_stage_if                                                |
// | Purpose  : Single-cycle instruction-memory handshake between the fetch   |
// |            stage (master) and the instruction memory (slave).            |
// | Signals  : imemAddr  - fetch address (PCF)                               |
// |            imemReq   - fetch request                                     |
// |            imemRdata - instruction word, valid when imemReady=1          |
// |            imemReady - word returned in the same cycle                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface fetch_stage_if #(
   parameter int XLEN = 32
) ();
   logic [XLEN-1:0] imemAddr;
   logic            imemReq;
   logic [31:0]     imemRdata;
   logic            imemReady;

   modport master (
      output imemAddr,
      output imemReq,
      input  imemRdata,
      input  imemReady
   );

   modport slave (
      input  imemAddr,
      input  imemReq,
      output imemRdata,
      output imemReady
   );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_stage                                                   |
// | Purpose  : IF stage plus IF/ID pipeline register. Holds PCF, selects the |
// |            next PC from the EX redirect, talks to instruction memory and |
// |            delivers InstrD/PCD/PCPlus4D to decode.                       |
// | Ports    : clk, rst (async, active-high)                                 |
// |            stallF, stallD, flushD        - hazard unit controls          |
// |            PCSrcE, PCTargetE, ALUResultE - EX-stage redirect             |
// |            imem (fetch_stage_if.master)  - instruction memory handshake  |
// |            InstrD, PCD, PCPlus4D, validD - decode-stage outputs          |
// |            fetchWait                     - memory-wait state indicator   |
// |            fetchCount, bubbleCount       - performance counters          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fetch_stage #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
   input  wire logic            clk,
   input  wire logic            rst,
   input  wire logic            stallF,
   input  wire logic            stallD,
   input  wire logic            flushD,
   input  wire logic [1:0]      PCSrcE,
   input  wire logic [XLEN-1:0] PCTargetE,
   input  wire logic [XLEN-1:0] ALUResultE,
   fetch_stage_if.master        imem,
   output logic [31:0]          InstrD,
   output logic [XLEN-1:0]      PCD,
   output logic [XLEN-1:0]      PCPlus4D,
   output logic                 validD,
   output logic                 fetchWait,
   output logic [31:0]          fetchCount,
   output logic [31:0]          bubbleCount
);

   typedef enum logic [0:0] {
      ST_FETCH = 1'b0,
      ST_WAIT  = 1'b1
   } state_t;

   localparam logic [XLEN-1:0] C_ALIGN_MASK = ~XLEN'(3);
   localparam logic [XLEN-1:0] C_FOUR       = XLEN'(4);

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     instr_q, instr_d;
   logic [XLEN-1:0] pcd_q, pcd_d;
   logic [XLEN-1:0] pcp4_q, pcp4_d;
   logic            valid_q, valid_d;
   logic [31:0]     fcnt_q, fcnt_d;
   logic [31:0]     bcnt_q, bcnt_d;

   logic            redirect;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] pc_plus4;

   // 2'b11 is reserved and falls through as sequential fetch.
   assign redirect = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
   assign target   = ((PCSrcE == 2'b10) ? ALUResultE : PCTargetE) & C_ALIGN_MASK;
   assign pc_plus4 = pc_q + C_FOUR;

   assign imem.imemAddr = pc_q;
   assign imem.imemReq  = ~rst;

   // PC selection and wait-state tracking.
   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;

      if (redirect) begin
         pc_d = target;
      end else if (!stallF && imem.imemReady) begin
         pc_d = pc_plus4;
      end

      case (state_q)
         ST_FETCH: begin
            if (!redirect && !stallF && !imem.imemReady) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A redirect abandons the outstanding word.
            if (imem.imemReady || redirect) begin
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_FETCH;
      endcase
   end

   // IF/ID register and counters.
   always_comb begin
      instr_d = instr_q;
      pcd_d   = pcd_q;
      pcp4_d  = pcp4_q;
      valid_d = valid_q;
      fcnt_d  = fcnt_q;
      bcnt_d  = bcnt_q;

      if (flushD) begin
         instr_d = NOP_INSTR;
         pcd_d   = '0;
         pcp4_d  = '0;
         valid_d = 1'b0;
      end else if (stallD) begin
         // hold everything
      end else if (imem.imemReady && !redirect) begin
         instr_d = imem.imemRdata;
         pcd_d   = pc_q;
         pcp4_d  = pc_plus4;
         valid_d = 1'b1;
         fcnt_d  = fcnt_q + 32'd1;
      end else begin
         instr_d = NOP_INSTR;
         pcd_d   = '0;
         pcp4_d  = '0;
         valid_d = 1'b0;
         // Only memory-induced bubbles are counted; redirect bubbles are not.
         if (!imem.imemReady) begin
            bcnt_d = bcnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         pcd_q   <= '0;
         pcp4_q  <= '0;
         valid_q <= 1'b0;
         fcnt_q  <= '0;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pcd_q   <= pcd_d;
         pcp4_q  <= pcp4_d;
         valid_q <= valid_d;
         fcnt_q  <= fcnt_d;
         bcnt_q  <= bcnt_d;
      end
   end

   assign InstrD      = instr_q;
   assign PCD         = pcd_q;
   assign PCPlus4D    = pcp4_q;
   assign validD      = valid_q;
   assign fetchWait   = (state_q == ST_WAIT);
   assign fetchCount  = fcnt_q;
   assign bubbleCount = bcnt_q;

endmodule
`default_nettype wire
